// File: rtl/sub_result_stage.sv
// Registered result stage behind the 3-bit subtractor: flags, reference check,
// a small FIFO toward the ALU output mux, a saturating borrow counter and a sticky error flag.
module sub_result_stage #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_a,
   input  logic [2:0]       in_b,
   input  logic [3:0]       in_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_diff,
   output logic             out_c,
   output logic             out_n,
   output logic             out_z,
   output logic             out_v,
   output logic             out_mis,
   output logic             err_sticky,
   output logic [CNT_W-1:0] borrow_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push, pop;
   logic [7:0]       entry;
   logic [7:0]       head;
   logic             ovf, mis;

   // A - B computed as A + ~B + 1, so bit 3 is carry-out (1 = no borrow).
   function automatic logic [3:0] sub_ref(input logic [2:0] a, input logic [2:0] b);
      return {1'b0, a} + {1'b0, ~b} + 4'd1;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Entry layout: {mis, v, z, n, c, diff[2:0]}.
   always_comb begin
      ovf   = (in_a[2] != in_b[2]) && (in_res[2] != in_a[2]);
      mis   = (in_res != sub_ref(in_a, in_b));
      entry = {mis, ovf, (in_res[2:0] == 3'd0), ~in_res[3], in_res[3], in_res[2:0]};
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (entry[7]) err_d = 1'b1;
         if (!in_res[3]) cnt_d = sat_inc(cnt_q);
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset; contents are only observed while out_valid is high.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= entry;
   end

   always_comb begin
      head = out_valid ? mem_q[rd_ptr_q] : 8'h00;
      out_diff = head[2:0];
      out_c    = head[3];
      out_n    = head[4];
      out_z    = head[5];
      out_v    = head[6];
      out_mis  = head[7];
   end

   assign err_sticky = err_q;
   assign borrow_cnt = cnt_q;

endmodule

// File: tb/tb_sub_result_stage.sv
// Self-checking bench for sub_result_stage: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_sub_result_stage;
   localparam int DEPTH = 2;
   localparam int CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       in_a = '0;
   logic [2:0]       in_b = '0;
   logic [3:0]       in_res = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [2:0]       out_diff;
   logic             out_c, out_n, out_z, out_v, out_mis;
   logic             err_sticky;
   logic [CNT_W-1:0] borrow_cnt;
   logic [8:0]       pay;

   typedef struct packed {
      logic [2:0] diff;
      logic c, n, z, v, mis;
   } ent_t;

   ent_t mq[$];
   logic m_err = 1'b0;
   int   m_cnt = 0;
   logic m_stall = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   assign pay = {out_valid, out_diff, out_c, out_n, out_z, out_v, out_mis};

   sub_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_res(in_res),
      .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff),
      .out_c(out_c), .out_n(out_n), .out_z(out_z), .out_v(out_v), .out_mis(out_mis),
      .err_sticky(err_sticky), .borrow_cnt(borrow_cnt)
   );

   function automatic logic [3:0] true_diff(input logic [2:0] a, input logic [2:0] b);
      int r;
      r = (int'(a) - int'(b) + 8) % 16;
      return 4'(r);
   endfunction

   function automatic ent_t model_entry(input logic [2:0] a, input logic [2:0] b, input logic [3:0] res);
      ent_t e;
      e.diff = res[2:0];
      e.c    = res[3];
      e.n    = !res[3];
      e.z    = (res[2:0] == 3'd0);
      e.v    = (a[2] != b[2]) && (res[2] != a[2]);
      e.mis  = (res != true_diff(a, b));
      return e;
   endfunction

   task automatic tick();
      logic push, pop;
      ent_t e;
      push = !rst && in_valid && (mq.size() != DEPTH);
      pop  = !rst && out_ready && (mq.size() != 0);
      e = model_entry(in_a, in_b, in_res);
      m_stall = in_valid && !push;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_err = 1'b0;
         m_cnt = 0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back(e);
            if (e.mis) m_err = 1'b1;
            if (!e.c && m_cnt < CNT_MAX) m_cnt++;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic push_one(input logic [2:0] a, input logic [2:0] b, input logic [3:0] res);
      in_a = a; in_b = b; in_res = res; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      in_a = 3'd2; in_b = 3'd5; in_res = 4'b0101;
      tick(); tick();
      rst = 1'b0; in_valid = 1'b0;
      total++; if (pay !== 9'd0) begin bad++; $display("FAIL reset_payload got=%b want=%b", pay, 9'd0); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (borrow_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", borrow_cnt); end
      total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_sticky); end
   endtask

   task automatic test_flags();
      do_reset();
      push_one(3'd5, 3'd3, 4'b1010);
      total++; if (pay !== 9'b1_010_10010) begin bad++; $display("FAIL flags_5m3 got=%b want=%b", pay, 9'b1_010_10010); end
      total++; if (borrow_cnt !== 2'd0) begin bad++; $display("FAIL flags_5m3_cnt got=%0d want=0", borrow_cnt); end
      push_one(3'd3, 3'd5, 4'b0110);
      total++; if (pay !== 9'b1_110_01010) begin bad++; $display("FAIL flags_3m5 got=%b want=%b", pay, 9'b1_110_01010); end
      total++; if (borrow_cnt !== 2'd1) begin bad++; $display("FAIL flags_3m5_cnt got=%0d want=1", borrow_cnt); end
      push_one(3'd3, 3'd3, 4'b1000);
      total++; if (pay !== 9'b1_000_10100) begin bad++; $display("FAIL flags_zero got=%b want=%b", pay, 9'b1_000_10100); end
   endtask

   task automatic test_overflow();
      push_one(3'd3, 3'd4, 4'b0111);
      total++; if (pay !== 9'b1_111_01010) begin bad++; $display("FAIL ovf_3m4 got=%b want=%b", pay, 9'b1_111_01010); end
      total++; if (borrow_cnt !== 2'd2) begin bad++; $display("FAIL ovf_3m4_cnt got=%0d want=2", borrow_cnt); end
      push_one(3'd4, 3'd1, 4'b1011);
      total++; if (pay !== 9'b1_011_10010) begin bad++; $display("FAIL ovf_4m1 got=%b want=%b", pay, 9'b1_011_10010); end
   endtask

   task automatic test_mismatch();
      push_one(3'd2, 3'd1, 4'b0000);
      total++; if (pay !== 9'b1_000_01101) begin bad++; $display("FAIL mis_flag got=%b want=%b", pay, 9'b1_000_01101); end
      total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL mis_err_set got=%b want=1", err_sticky); end
      push_one(3'd2, 3'd1, 4'b1001);
      total++; if (pay !== 9'b1_001_10000) begin bad++; $display("FAIL mis_clean got=%b want=%b", pay, 9'b1_001_10000); end
      tick();
      total++; if ({out_valid, err_sticky} !== 2'b01) begin bad++; $display("FAIL mis_err_hold got=%b want=01", {out_valid, err_sticky}); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      in_a = 3'd6; in_b = 3'd1; in_res = 4'b1101;
      tick();
      total++; if ({out_valid, in_ready, out_diff} !== 5'b11_101) begin bad++; $display("FAIL bp_first got=%b want=11101", {out_valid, in_ready, out_diff}); end
      in_a = 3'd1; in_b = 3'd1; in_res = 4'b1000;
      tick();
      total++; if ({out_valid, in_ready, out_diff} !== 5'b10_101) begin bad++; $display("FAIL bp_full got=%b want=10101", {out_valid, in_ready, out_diff}); end
      in_a = 3'd7; in_b = 3'd5; in_res = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if ({out_valid, in_ready, out_diff} !== 5'b10_101) begin bad++; $display("FAIL bp_stall%0d got=%b want=10101", i, {out_valid, in_ready, out_diff}); end
      end
      out_ready = 1'b1;
      tick();
      total++; if ({out_valid, in_ready, out_diff} !== 5'b11_000) begin bad++; $display("FAIL bp_pop1 got=%b want=11000", {out_valid, in_ready, out_diff}); end
      tick();
      total++; if ({out_valid, in_ready, out_diff} !== 5'b11_010) begin bad++; $display("FAIL bp_held_push got=%b want=11010", {out_valid, in_ready, out_diff}); end
      in_valid = 1'b0;
      tick();
      total++; if ({out_valid, in_ready, out_diff} !== 5'b01_000) begin bad++; $display("FAIL bp_drain got=%b want=01000", {out_valid, in_ready, out_diff}); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         push_one(3'd1, 3'd2, 4'b0111);
         total++; if (borrow_cnt !== CNT_W'((i < CNT_MAX) ? i : CNT_MAX)) begin bad++; $display("FAIL sat_cnt%0d got=%0d want=%0d", i, borrow_cnt, (i < CNT_MAX) ? i : CNT_MAX); end
      end
      out_ready = 1'b0; in_valid = 1'b1;
      in_a = 3'd2; in_b = 3'd1; in_res = 4'b0000;
      tick();
      in_a = 3'd3; in_b = 3'd1; in_res = 4'b1010;
      tick();
      total++; if ({out_valid, in_ready, err_sticky} !== 3'b101) begin bad++; $display("FAIL sat_full got=%b want=101", {out_valid, in_ready, err_sticky}); end
      rst = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      total++; if ({out_valid, in_ready, err_sticky, borrow_cnt, pay} !== {1'b0, 1'b1, 1'b0, 2'd0, 9'd0}) begin bad++; $display("FAIL midrst got=%b want=%b", {out_valid, in_ready, err_sticky, borrow_cnt, pay}, {1'b0, 1'b1, 1'b0, 2'd0, 9'd0}); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_discard got=%b want=0", out_valid); end
   endtask

   task automatic test_random();
      ent_t h;
      logic [12:0] exp_v, act_v;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!m_stall) begin
            in_valid = ($urandom_range(3) != 0);
            in_a = 3'($urandom_range(7));
            in_b = 3'($urandom_range(7));
            in_res = true_diff(in_a, in_b);
            if ($urandom_range(7) == 0) in_res = in_res ^ 4'($urandom_range(15, 1));
         end
         out_ready = ($urandom_range(2) != 0);
         tick();
         h = (mq.size() != 0) ? mq[0] : '0;
         exp_v = {mq.size() != 0, mq.size() != DEPTH, h, m_err, CNT_W'(m_cnt)};
         act_v = {out_valid, in_ready, out_diff, out_c, out_n, out_z, out_v, out_mis, err_sticky, borrow_cnt};
         total++; if (act_v !== exp_v) begin bad++; $display("FAIL rand_cyc%0d got=%b want=%b", cyc, act_v, exp_v); end
      end
   endtask

   initial begin
      test_reset();
      test_flags();
      test_overflow();
      test_mismatch();
      test_back_to_back();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
